// File: rtl/demultiplexer_router_if.sv
// Handshake bundle for the 1:4 demultiplexing router: one producer port
// (SELECT/IN/IN_VALID/IN_READY) and four consumer channels A..D.
interface demultiplexer_router_if #(
  parameter int q = 7
);
  logic [1:0] SELECT;
  logic [q:0] IN;
  logic       IN_VALID;
  logic       IN_READY;

  logic [q:0] A, B, C, D;
  logic       A_VALID, B_VALID, C_VALID, D_VALID;
  logic       A_READY, B_READY, C_READY, D_READY;

  logic       BUSY;

  // Environment side: drives the producer word and the consumer readies.
  modport master (
    output SELECT, IN, IN_VALID,
    output A_READY, B_READY, C_READY, D_READY,
    input  IN_READY, BUSY,
    input  A, B, C, D,
    input  A_VALID, B_VALID, C_VALID, D_VALID
  );

  // Router side.
  modport slave (
    input  SELECT, IN, IN_VALID,
    input  A_READY, B_READY, C_READY, D_READY,
    output IN_READY, BUSY,
    output A, B, C, D,
    output A_VALID, B_VALID, C_VALID, D_VALID
  );
endinterface

// File: rtl/demultiplexer_router.sv
// 1:4 demultiplexing router. Each consumer channel owns a one-entry
// registered slot, so a stalled channel only blocks words addressed to it.

// One output slot: holds a word until its consumer takes it. A drain and a
// load on the same edge keep the slot full with the new word.
module demultiplexer_router_slot #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Next state: drain clears the slot, a load (which wins) refills it.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (ready_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Slot registers; reset discards any pending word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
endmodule

module demultiplexer_router #(
  parameter int q = 7
) (
  input logic                  CLK,
  input logic                  RST,
  demultiplexer_router_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]      rdy, load, full;
  logic [NUM_LANES-1:0][q:0] dat;
  logic                      in_ready;

  assign rdy = {bus.D_READY, bus.C_READY, bus.B_READY, bus.A_READY};

  // Accept whenever the addressed slot is empty or is draining this edge;
  // IN_VALID deliberately does not feed back into IN_READY.
  always_comb in_ready = ~full[bus.SELECT] | rdy[bus.SELECT];

  // Steer the accepted word to exactly one slot.
  always_comb begin
    load = '0;
    load[bus.SELECT] = bus.IN_VALID & in_ready;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demultiplexer_router_slot #(.W(q+1)) u_slot (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (load[k]),
      .data_i  (bus.IN),
      .ready_i (rdy[k]),
      .valid_o (full[k]),
      .data_o  (dat[k])
    );
  end

  assign bus.IN_READY = in_ready;
  assign bus.BUSY     = |full;
  assign bus.A        = dat[0];
  assign bus.B        = dat[1];
  assign bus.C        = dat[2];
  assign bus.D        = dat[3];
  assign bus.A_VALID  = full[0];
  assign bus.B_VALID  = full[1];
  assign bus.C_VALID  = full[2];
  assign bus.D_VALID  = full[3];
endmodule

// File: tb/tb_demultiplexer_router.sv
// Bench for demultiplexer_router: directed vector table, hand-written
// corner sequences and a random run against a per-channel queue model.
module tb_demultiplexer_router;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  demultiplexer_router_if #(.q(7)) bus ();
  demultiplexer_router #(.q(7)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] din;
    logic       iv;
    logic [3:0] rdy;      // {D,C,B,A}
    logic       exp_ir;   // before the edge
    logic [3:0] exp_vld;  // after the edge, {D,C,B,A}
    logic       exp_busy;
    int         ch;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t tbl[14];

  logic [7:0] mq[4][$];
  logic [7:0] mlast[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic v, input logic [3:0] r);
    bus.SELECT   = s;
    bus.IN       = d;
    bus.IN_VALID = v;
    {bus.D_READY, bus.C_READY, bus.B_READY, bus.A_READY} = r;
  endtask

  function automatic logic [3:0] vld();
    return {bus.D_VALID, bus.C_VALID, bus.B_VALID, bus.A_VALID};
  endfunction

  function automatic logic [7:0] dat(input int k);
    case (k)
      0:       return bus.A;
      1:       return bus.B;
      2:       return bus.C;
      default: return bus.D;
    endcase
  endfunction

  initial begin
    logic [1:0] s;
    logic [7:0] d;
    logic       v;
    logic [3:0] r;
    logic       eir;

    //            sel   din    iv  rdy      ir  vld      busy ch dat
    tbl[0]  = '{2'd0, 8'hA0, 1, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0};
    tbl[1]  = '{2'd1, 8'hB1, 1, 4'b1111, 1, 4'b0010, 1, 1, 8'hB1};
    tbl[2]  = '{2'd2, 8'hC2, 1, 4'b1111, 1, 4'b0100, 1, 2, 8'hC2};
    tbl[3]  = '{2'd3, 8'hD3, 1, 4'b1111, 1, 4'b1000, 1, 3, 8'hD3};
    tbl[4]  = '{2'd0, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 3, 8'hD3};
    tbl[5]  = '{2'd1, 8'h55, 1, 4'b1101, 1, 4'b0010, 1, 1, 8'h55};
    tbl[6]  = '{2'd1, 8'h66, 1, 4'b1101, 0, 4'b0010, 1, 1, 8'h55};
    tbl[7]  = '{2'd3, 8'h77, 1, 4'b1101, 1, 4'b1010, 1, 3, 8'h77};
    tbl[8]  = '{2'd1, 8'h66, 1, 4'b1111, 1, 4'b0010, 1, 1, 8'h66};
    tbl[9]  = '{2'd1, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 1, 8'h66};
    tbl[10] = '{2'd0, 8'h10, 1, 4'b1110, 1, 4'b0001, 1, 0, 8'h10};
    tbl[11] = '{2'd0, 8'h20, 1, 4'b1111, 1, 4'b0001, 1, 0, 8'h20};
    tbl[12] = '{2'd0, 8'h00, 0, 4'b0000, 0, 4'b0001, 1, 0, 8'h20};
    tbl[13] = '{2'd0, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 0, 8'h20};

    // Reset state
    drive(2'd0, 8'h00, 1'b0, 4'b0000);
    #2;
    chk("rst_vld", 32'(vld()), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_ir", 32'(bus.IN_READY), 32'h1);
    chk("rst_A", 32'(bus.A), 32'h0);
    @(negedge CLK); RST = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      drive(tbl[i].sel, tbl[i].din, tbl[i].iv, tbl[i].rdy);
      #1 chk($sformatf("tbl%0d_ir", i), 32'(bus.IN_READY), 32'(tbl[i].exp_ir));
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_vld", i), 32'(vld()), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.BUSY), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_dat", i), 32'(dat(tbl[i].ch)), 32'(tbl[i].exp_dat));
    end

    // Reset mid-stream: A and C stalled full, reset between edges
    @(negedge CLK); drive(2'd0, 8'h11, 1'b1, 4'b0000);
    @(negedge CLK); drive(2'd2, 8'h33, 1'b1, 4'b0000);
    @(posedge CLK); #1;
    chk("mid_vld_pre", 32'(vld()), 32'b0101);
    @(negedge CLK); drive(2'd0, 8'h00, 1'b0, 4'b0000);
    #1 chk("mid_ir_stall", 32'(bus.IN_READY), 32'h0);
    #1 RST = 1'b1;
    #1;
    chk("mid_vld", 32'(vld()), 32'h0);
    chk("mid_busy", 32'(bus.BUSY), 32'h0);
    chk("mid_ir", 32'(bus.IN_READY), 32'h1);
    for (int k = 0; k < 4; k++) chk($sformatf("mid_dat%0d", k), 32'(dat(k)), 32'h0);
    @(negedge CLK); RST = 1'b0;

    // Back-to-back throughput into A
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      drive(2'd0, 8'(i), 1'b1, 4'b0001);
      #1 chk($sformatf("b2b%0d_ir", i), 32'(bus.IN_READY), 32'h1);
      @(posedge CLK); #1;
      chk($sformatf("b2b%0d_vld", i), 32'(bus.A_VALID), 32'h1);
      chk($sformatf("b2b%0d_A", i), 32'(bus.A), 32'(i));
    end
    @(negedge CLK); drive(2'd0, 8'h00, 1'b0, 4'b0001);
    @(posedge CLK); #1;
    chk("b2b_end_vld", 32'(bus.A_VALID), 32'h0);

    // Idle with readies toggling: nothing appears, outputs hold
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive(2'(i), 8'hFF, 1'b0, 4'($urandom));
      @(posedge CLK); #1;
      chk($sformatf("idle%0d_vld", i), 32'(vld()), 32'h0);
      chk($sformatf("idle%0d_busy", i), 32'(bus.BUSY), 32'h0);
      chk($sformatf("idle%0d_A", i), 32'(bus.A), 32'h08);
    end

    // Random run against queue model, starting from reset
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mlast[k] = 8'h00;
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      s = 2'($urandom);
      d = 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 2) != 0);
      drive(s, d, v, r);
      eir = (mq[s].size() == 0) || r[s];
      #1 chk("rnd_ir", 32'(bus.IN_READY), 32'(eir));
      for (int k = 0; k < 4; k++)
        if (mq[k].size() > 0 && r[k]) void'(mq[k].pop_front());
      if (v && eir) begin
        mq[s].push_back(d);
        mlast[s] = d;
      end
      @(posedge CLK); #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd_vld%0d", k), 32'(vld()) >> k & 32'h1, 32'(mq[k].size() != 0));
        chk($sformatf("rnd_dat%0d", k), 32'(dat(k)), 32'(mlast[k]));
      end
      chk("rnd_busy", 32'(bus.BUSY),
          32'((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
